// File: rtl/uart_tx_arbiter.sv
// Round-robin packet arbiter sharing one uart_tx byte transmitter between N_REQ requesters.
// Optional macro UART_ARB_TAG_EN prefixes each packet with the tag byte TAG_BASE+k.
module uart_tx_arbiter #(
   parameter int          N_REQ    = 2,
   parameter logic [7:0]  TAG_BASE = 8'h30
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic [N_REQ-1:0]     i_req,
   input  logic [8*N_REQ-1:0]   i_data,
   input  logic [N_REQ-1:0]     i_last,
   output logic [N_REQ-1:0]     o_ack,
   output logic [N_REQ-1:0]     o_grant,
   output logic                 o_write,
   output logic [7:0]           o_data,
   input  logic                 i_busy
);

   localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam logic [IW:0]   NR       = (IW+1)'(N_REQ);
   localparam logic [IW-1:0] LAST_IDX = IW'(N_REQ-1);

`ifdef UART_ARB_TAG_EN
   typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_HOLD, S_TAG} state_t;
`else
   typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_HOLD} state_t;
`endif

   state_t          r_state;
   logic [IW-1:0]   r_ptr;
   logic [IW-1:0]   r_owner;
   logic            r_last_q;

   logic            w_found;
   logic [IW-1:0]   w_pick;
   logic [IW:0]     w_sum;
   logic [N_REQ-1:0] w_pick_oh;
   logic [7:0]      w_pick_data;
   logic            w_pick_last;
   logic [7:0]      w_own_data;
   logic            w_own_last;
   logic            w_own_req;
   logic [IW-1:0]   w_next_ptr;

   // First requester at or above the pointer, wrapping at N_REQ-1.
   always_comb begin
      w_found = 1'b0;
      w_pick  = '0;
      w_sum   = '0;
      for (int i = 0; i < N_REQ; i++) begin
         w_sum = {1'b0, r_ptr} + (IW+1)'(i);
         if (w_sum >= NR) w_sum = w_sum - NR;
         if (!w_found && i_req[w_sum[IW-1:0]]) begin
            w_found = 1'b1;
            w_pick  = w_sum[IW-1:0];
         end
      end
   end

   always_comb begin
      w_pick_oh   = '0;
      w_pick_data = '0;
      w_pick_last = 1'b0;
      w_own_data  = '0;
      w_own_last  = 1'b0;
      w_own_req   = 1'b0;
      for (int k = 0; k < N_REQ; k++) begin
         if (w_pick == IW'(k)) begin
            w_pick_oh[k] = 1'b1;
            w_pick_data  = i_data[8*k +: 8];
            w_pick_last  = i_last[k];
         end
         if (r_owner == IW'(k)) begin
            w_own_data = i_data[8*k +: 8];
            w_own_last = i_last[k];
            w_own_req  = i_req[k];
         end
      end
   end

   assign w_next_ptr = (r_owner == LAST_IDX) ? '0 : r_owner + 1'b1;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state  <= S_IDLE;
         r_ptr    <= '0;
         r_owner  <= '0;
         r_last_q <= 1'b0;
         o_write  <= 1'b0;
         o_data   <= 8'h00;
         o_ack    <= '0;
         o_grant  <= '0;
      end else begin
         o_ack <= '0;
         case (r_state)
            S_IDLE: begin
               // Busy may still be high after reset while uart_tx finishes a byte.
               if (!i_busy && w_found) begin
                  r_owner <= w_pick;
                  o_grant <= w_pick_oh;
`ifdef UART_ARB_TAG_EN
                  r_state <= S_TAG;
`else
                  o_data   <= w_pick_data;
                  r_last_q <= w_pick_last;
                  o_ack    <= w_pick_oh;
                  o_write  <= 1'b1;
                  r_state  <= S_ISSUE;
`endif
               end
            end
`ifdef UART_ARB_TAG_EN
            S_TAG: begin
               o_data   <= TAG_BASE + {{(8-IW){1'b0}}, r_owner};
               r_last_q <= 1'b0;
               o_write  <= 1'b1;
               r_state  <= S_ISSUE;
            end
`endif
            S_ISSUE: begin
               // uart_tx samples i_write only on its bit tick; hold until busy proves it.
               if (i_busy) begin
                  o_write <= 1'b0;
                  r_state <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (!i_busy) begin
                  if (r_last_q) begin
                     o_grant <= '0;
                     r_ptr   <= w_next_ptr;
                     r_state <= S_IDLE;
                  end else begin
                     r_state <= S_HOLD;
                  end
               end
            end
            S_HOLD: begin
               if (w_own_req) begin
                  o_data   <= w_own_data;
                  r_last_q <= w_own_last;
                  o_ack    <= o_grant;
                  o_write  <= 1'b1;
                  r_state  <= S_ISSUE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
